// File: rtl/tff_counter.sv
// tff_counter: a WIDTH-bit register bank that works either as independent
// per-bit T flip-flops or as a modulo-MODULUS up/down counter with parallel load.
// Q and Ovf are the only state. Qbar and Tc are combinational views of that state.
module tff_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2 ** WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] T,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar,
  output logic             Tc,
  output logic             Ovf
);

  // Parameters outside the supported range are rejected at elaboration.
  if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_params
    $error("tff_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_t;

  // Largest in-range count. With MODULUS = 2**WIDTH this is all ones.
  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(MODULUS - 1);

  mode_t            mode;
  logic             at_top;
  logic             at_zero;
  logic             wrap;
  logic [WIDTH-1:0] q_next;

  assign mode = mode_t'(Mode);

  // Up-count wraps from any value at or above the top. This recovers
  // out-of-range values that toggle or load modes leave behind.
  assign at_top  = (Q >= MaxCount);
  assign at_zero = (Q == '0);

  // The wrap condition is also the terminal-count indication for the coming edge.
  always_comb begin
    wrap = 1'b0;
    if (En) begin
      unique case (mode)
        MODE_UP:   wrap = at_top;
        MODE_DOWN: wrap = at_zero;
        default:   wrap = 1'b0;
      endcase
    end
  end

  // Select the next register value from the mode. Holding is the default.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    q_next = Q;
    if (En) begin
      unique case (mode)
        MODE_TOGGLE: q_next = Q ^ T;
        MODE_UP:     q_next = at_top  ? '0       : Q + 1'b1;
        MODE_DOWN:   q_next = at_zero ? MaxCount : Q - 1'b1;
        MODE_LOAD:   q_next = D;
        default:     q_next = Q;
      endcase
    end
  end

  // State register. Reset asynchronously clears the count and any pending wrap pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    // NOTE: non-blocking assignments let every flop sample pre-edge values, independent of statement order.
    if (!Reset) begin
      Q   <= '0;
      Ovf <= 1'b0;
    end else begin
      Q   <= q_next;
      Ovf <= wrap;
    end
  end

  assign Qbar = ~Q;
  assign Tc   = wrap;

endmodule
